// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a synchronous FIFO word by word:
// start bit, DATA_WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, POP, LOAD, START, DATA, PAR, STOP
    } state_t;

    state_t                state;
    logic [BW-1:0]         baud;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  par_bit;
    logic                  baud_end;

    assign baud_end  = (baud == BAUD_LAST);
    assign shift_nxt = shift_reg >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            fifo_r_en  <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (en && !fifo_empty) begin
                        fifo_r_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= POP;
                    end
                end
                // FIFO samples the strobe on this edge; its data_out is valid in LOAD.
                POP: begin
                    fifo_r_en <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
                    par_bit   <= ^fifo_data;
                    tx        <= 1'b0;
                    baud      <= '0;
                    bit_idx   <= '0;
                    state     <= START;
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_nxt;
                            tx        <= shift_nxt[0];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                PAR: begin
                    if (baud_end) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    // Registered pulse: raised one edge early so it lands on the final cycle.
                    frame_done <= (baud == BAUD_PRE) && (bit_idx == STOP_LAST);
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    fifo_r_en <= 1'b0;
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed by behavioural FIFOs,
// serial frames decoded and compared against a scoreboard of expected frames.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk;
    logic reset;
    logic en;
    logic [1:0]      fempty;
    logic [1:0][7:0] fdata;
    logic [1:0]      r_en;
    logic [1:0]      tx;
    logic [1:0]      busy;
    logic [1:0]      fdone;

    logic [7:0] mem [2][256];
    int wr [2];
    int rd [2];
    int pops [2];
    int frames [2];
    logic [10:0] sb0 [$];
    logic [10:0] sb1 [$];

    int errors;
    int total;

    typedef struct {
        int          d;
        logic [7:0]  w;
        logic [10:0] e;
    } vec_t;
    vec_t tbl [6];

    assign fempty[0] = (wr[0] == rd[0]);
    assign fempty[1] = (wr[1] == rd[1]);

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
        .fifo_r_en(r_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fdone[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
        .fifo_r_en(r_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fdone[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] fbits(input int d, input logic [7:0] w);
        if (d == 0) return {1'b0, 1'b1, w, 1'b0};
        return {1'b1, ^w, w, 1'b0};
    endfunction

    task automatic sb_add(input int d, input logic [10:0] e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic push(input int d, input logic [7:0] w, input logic [10:0] e, input bit sbp);
        mem[d][wr[d] % 256] = w;
        wr[d] = wr[d] + 1;
        if (sbp) sb_add(d, e);
    endtask

    task automatic wait_frames(input int d, input int target);
        for (int k = 0; k < 3000; k++) begin
            if (frames[d] >= target) break;
            @(negedge clk);
        end
        check($sformatf("wait_frames%0d", d), 32'(frames[d] >= target), 1);
    endtask

    // FIFO read side: data_out updates on the edge that samples r_en.
    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (r_en[d]) begin
                    check($sformatf("ren_nonempty%0d", d), 32'(wr[d] != rd[d]), 1);
                    pops[d] = pops[d] + 1;
                    fdata[d] <= mem[d][rd[d] % 256];
                    rd[d] <= rd[d] + 1;
                end
            end
        end
    end

    task automatic monitor(input int d);
        int cnt;
        int gap;
        int nb;
        logic act;
        logic havep;
        logic [10:0] bits;
        logic [10:0] e;
        nb = (d == 0) ? 10 : 11;
        act = 1'b0; havep = 1'b0; gap = 0; cnt = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (act) begin
                    if (d == 0 && sb0.size() > 0) void'(sb0.pop_front());
                    if (d == 1 && sb1.size() > 0) void'(sb1.pop_front());
                end
                act = 1'b0; havep = 1'b0; gap = 0;
            end else if (!act && tx[d]) begin
                gap++;
            end else begin
                if (!act) begin
                    act = 1'b1; cnt = 1; bits = '0;
                    if (havep) check($sformatf("gap%0d", d), 32'(gap >= 3), 1);
                end else begin
                    cnt++;
                end
                if (cnt % CPB == 2) bits[cnt / CPB] = tx[d];
                if (cnt == nb * CPB) begin
                    check($sformatf("frame_done%0d", d), 32'(fdone[d]), 1);
                    check($sformatf("busy_end%0d", d), 32'(busy[d]), 1);
                    if (d == 0) begin
                        if (sb0.size() == 0) begin check("sb0_empty", 1, 0); e = '0; end
                        else e = sb0.pop_front();
                    end else begin
                        if (sb1.size() == 0) begin check("sb1_empty", 1, 0); e = '0; end
                        else e = sb1.pop_front();
                    end
                    check($sformatf("frame%0d", d), 32'(bits), 32'(e));
                    frames[d] = frames[d] + 1;
                    act = 1'b0; gap = 0; havep = 1'b1;
                end else if (fdone[d]) begin
                    check($sformatf("early_frame_done%0d", d), 1, 0);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        int bp;
        int bf;
        tbl[0] = '{0, 8'h00, 11'h200};
        tbl[1] = '{0, 8'hFF, 11'h3FE};
        tbl[2] = '{1, 8'hFF, 11'h5FE};
        tbl[3] = '{1, 8'h01, 11'h602};
        tbl[4] = '{0, 8'h3C, 11'h278};
        tbl[5] = '{1, 8'h80, 11'h700};

        errors = 0; total = 0;
        fdata = '0;
        reset = 1'b0;
        en    = 1'b1;

        // Reset held with a non-empty FIFO and en=1: nothing moves.
        push(0, 8'hA5, 11'h34A, 1);
        repeat (4) begin
            @(negedge clk);
            check("rst_tx0", 32'(tx[0]), 1);
            check("rst_ren0", 32'(r_en[0]), 0);
            check("rst_busy0", 32'(busy[0]), 0);
            check("rst_tx1", 32'(tx[1]), 1);
        end

        reset = 1'b1;
        @(negedge clk);
        check("lat_ren_on", 32'(r_en[0]), 1);
        check("lat_busy", 32'(busy[0]), 1);
        check("lat_tx_pop", 32'(tx[0]), 1);
        @(negedge clk);
        check("lat_ren_off", 32'(r_en[0]), 0);
        check("lat_tx_load", 32'(tx[0]), 1);
        @(negedge clk);
        check("lat_tx_fall", 32'(tx[0]), 0);
        wait_frames(0, 1);
        check("pops_single", 32'(pops[0]), 1);

        for (int i = 0; i < 6; i++) begin
            push(tbl[i].d, tbl[i].w, tbl[i].e, 1);
            wait_frames(tbl[i].d, frames[tbl[i].d] + 1);
        end

        // Parity instance, back-to-back frames.
        bf = frames[1];
        push(1, 8'hA5, 11'h54A, 1);
        push(1, 8'h07, 11'h60E, 1);
        wait_frames(1, bf + 2);

        // Drain eight words.
        bp = pops[0]; bf = frames[0];
        for (int w = 1; w <= 8; w++) push(0, 8'(w), fbits(0, 8'(w)), 1);
        wait_frames(0, bf + 8);
        repeat (20) @(negedge clk);
        check("drain_pops", 32'(pops[0] - bp), 8);
        check("drain_busy", 32'(busy[0]), 0);
        check("drain_tx", 32'(tx[0]), 1);

        // en dropped while frame 2 of 4 is on the line.
        bp = pops[0]; bf = frames[0];
        for (int w = 0; w < 4; w++) push(0, 8'(8'h30 + w), fbits(0, 8'(8'h30 + w)), w < 2);
        wait_frames(0, bf + 1);
        repeat (10) @(negedge clk);
        check("en_drop_busy", 32'(busy[0]), 1);
        en = 1'b0;
        wait_frames(0, bf + 2);
        repeat (50) @(negedge clk);
        check("en_drop_pops", 32'(pops[0] - bp), 2);
        check("en_drop_idle", 32'(busy[0]), 0);
        check("en_drop_frames", 32'(frames[0] - bf), 2);
        sb_add(0, fbits(0, 8'h32));
        sb_add(0, fbits(0, 8'h33));
        en = 1'b1;
        wait_frames(0, bf + 4);

        // Async reset in the middle of data bit 3.
        bp = pops[0];
        push(0, 8'h5A, fbits(0, 8'h5A), 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx[0] == 1'b0) break;
        end
        check("abort_started", 32'(tx[0]), 0);
        repeat (17) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx[0]), 1);
        check("abort_busy", 32'(busy[0]), 0);
        check("abort_fdone", 32'(fdone[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bf = frames[0];
        push(0, 8'hC3, fbits(0, 8'hC3), 1);
        wait_frames(0, bf + 1);
        check("abort_new_pop", 32'(pops[0] - bp), 2);

        repeat (10) @(negedge clk);
        check("sb0_drained", 32'(sb0.size()), 0);
        check("sb1_drained", 32'(sb1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
